pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter stage of the instruction-fetch path. It holds the current instruction address in a 32-bit register. A structural 32-bit ripple-carry adder computes the sequential address (addr + 4) every cycle. On each rising clock edge the register loads either the sequential address or a redirect target, subject to a write-enable for pipeline stalls.

Parameters:
RESET_ADDR, 32'h0000_0000, value loaded into the PC on reset; must be word-aligned (bits [1:0] = 0).
INCREMENT, 32'd4, constant added to the PC each sequential step.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
pc_en  input  1  PC write enable; 0 = hold (stall).
redirect  input  1  1 = load redirect_addr instead of the sequential address.
redirect_addr  input  32  branch/jump target address.
addr  output  32  current PC (registered).
new_addr  output  32  addr + INCREMENT (combinational adder sum).
c_out  output  1  carry-out of the 32-bit adder (address wrap indicator).

Behaviour:
- Reset: rst_n low clears state immediately, with no clock required.
  - addr = RESET_ADDR while rst_n is low.
  - new_addr = RESET_ADDR + 4 and c_out = carry of that sum, both combinational.
  - Deassertion takes effect at the next rising clk edge.
- Adder:
  - Structural ripple-carry chain of 32 one-bit full adders: sum_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | c_i&(a_i^b_i).
  - Operands: a = addr, b = INCREMENT, c_in = 0.
  - new_addr = (a + b + c_in) mod 2^32; c_out = bit 32 of the full sum.
  - Purely combinational, zero-cycle latency from addr.
  - The adder is a reusable submodule with ports a[31:0], b[31:0], c_in, sum[31:0], c_out.
- Register update on rising clk edge, with rst_n high, in priority order:
  1. pc_en = 0: addr holds. redirect is ignored and the redirect is lost.
  2. redirect = 1: addr <= {redirect_addr[31:2], 2'b00}. The low two bits are forced to zero to keep word alignment.
  3. Otherwise: addr <= new_addr.
- Latency: a redirect asserted in cycle N is visible on addr after edge N. new_addr follows one adder delay later.
- Wrap-around:
  - addr = 32'hFFFF_FFFC gives new_addr = 32'h0000_0000 and c_out = 1.
  - The next sequential edge loads 0. No trap is raised; c_out is informational only.
  - c_out = 0 for all other aligned addresses.
- Simultaneous events:
  - rst_n low overrides clk, pc_en and redirect.
  - pc_en = 0 overrides redirect.
- Reset mid-operation: asserting rst_n between edges forces addr to RESET_ADDR at once. No partial update is allowed.
- No X propagation: all outputs are defined from reset onward. The inputs pc_en, redirect and redirect_addr are assumed driven whenever rst_n is high.

Test Plan:
- Reset: rst_n = 0 -> addr = 0x0, new_addr = 0x4, c_out = 0. Release, then 5 clk edges with pc_en = 1, redirect = 0 -> addr sequence 0x4, 0x8, 0xC, 0x10, 0x14.
- Stall: at addr = 0x8, pc_en = 0 for 3 edges, with redirect = 1 and redirect_addr = 0x200 also driven -> addr stays 0x8 and new_addr stays 0xC. pc_en = 1 with redirect = 0 -> 0xC.
- Redirect: redirect = 1, redirect_addr = 0x100 for one edge -> addr = 0x100. Next sequential edge -> 0x104. redirect_addr = 0x1003 -> addr = 0x1000.
- Wrap: redirect to 0xFFFF_FFFC -> new_addr = 0x0, c_out = 1. Next edge -> addr = 0x0, c_out = 0.
- Async reset mid-cycle: at addr = 0x14, pull rst_n low between edges -> addr = 0x0 immediately, before the next edge. Hold low across edges -> addr stays 0x0.
- Adder standalone: a = 0x7FFF_FFFF, b = 1, c_in = 0 -> sum = 0x8000_0000, c_out = 0. a = 0xFFFF_FFFF, b = 0, c_in = 1 -> sum = 0x0, c_out = 1.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the fetch path: a word-aligned PC register with
// stall and redirect, plus a ripple-carry incrementer for the sequential address.

module pc_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [32:0] carry;

  assign carry[0] = c_in;

  // One full adder per bit; the carry ripples from bit 0 to bit 31.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[32];

endmodule

module pc_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INCREMENT  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic [31:0] addr,
  output logic [31:0] new_addr,
  output logic        c_out
);

  logic [31:0] addr_reg;
  logic [31:0] addr_next;
  logic [31:0] seq_addr;
  logic        seq_carry;

  pc_adder32 u_adder (
    .a     (addr_reg),
    .b     (INCREMENT),
    .c_in  (1'b0),
    .sum   (seq_addr),
    .c_out (seq_carry)
  );

  // A stall wins over a redirect; the dropped redirect is not remembered.
  always_comb begin
    addr_next = addr_reg;
    if (pc_en) begin
      if (redirect) begin
        addr_next = redirect_addr & 32'hFFFF_FFFC;
      end else begin
        addr_next = seq_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= RESET_ADDR;
    end else begin
      addr_reg <= addr_next;
    end
  end

  assign addr     = addr_reg;
  assign new_addr = seq_addr;
  assign c_out    = seq_carry;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit and its ripple-carry adder.

`timescale 1ns/1ps

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] addr;
  logic [31:0] new_addr;
  logic        c_out;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  int total_cnt;
  int bad_cnt;

  pc_fetch_unit #(
    .RESET_ADDR (32'h0000_0000),
    .INCREMENT  (32'd4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_en         (pc_en),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .addr          (addr),
    .new_addr      (new_addr),
    .c_out         (c_out)
  );

  pc_adder32 u_add (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp_addr);
    logic [32:0] full;
    full = {1'b0, exp_addr} + 33'd4;
    check_val({tag, ".addr"}, addr, exp_addr);
    check_val({tag, ".new_addr"}, new_addr, full[31:0]);
    check_val({tag, ".c_out"}, {31'd0, c_out}, {31'd0, full[32]});
  endtask

  logic [31:0] seq_exp [5];

  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    rst_n         = 1'b0;
    pc_en         = 1'b1;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    add_a         = 32'h0;
    add_b         = 32'h0;
    add_cin       = 1'b0;
    seq_exp[0] = 32'h4;
    seq_exp[1] = 32'h8;
    seq_exp[2] = 32'hC;
    seq_exp[3] = 32'h10;
    seq_exp[4] = 32'h14;

    // Reset state, then five sequential steps.
    #2;
    check_val("reset.addr", addr, 32'h0);
    check_val("reset.new_addr", new_addr, 32'h4);
    check_val("reset.c_out", {31'd0, c_out}, 32'd0);
    step();
    check_val("reset_held_edge.addr", addr, 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val($sformatf("seq%0d.addr", i), addr, seq_exp[i]);
    end

    // Asynchronous reset between edges, then held across edges.
    #2 rst_n = 1'b0;
    #1;
    check_pc("async_rst", 32'h0);
    step();
    check_pc("async_rst_hold1", 32'h0);
    step();
    check_pc("async_rst_hold2", 32'h0);
    #2 rst_n = 1'b1;
    step();
    step();
    check_pc("rerun", 32'h8);

    // Stall with a redirect pending: redirect is dropped.
    pc_en         = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      check_pc($sformatf("stall%0d", i), 32'h8);
    end
    pc_en    = 1'b1;
    redirect = 1'b0;
    step();
    check_pc("unstall", 32'hC);

    // Redirects, including the alignment masking.
    redirect      = 1'b1;
    redirect_addr = 32'h100;
    step();
    check_pc("redir_100", 32'h100);
    redirect = 1'b0;
    step();
    check_pc("after_redir", 32'h104);
    redirect      = 1'b1;
    redirect_addr = 32'h1003;
    step();
    check_pc("redir_align", 32'h1000);

    // Wrap-around at the top of the address space.
    redirect_addr = 32'hFFFF_FFFC;
    step();
    check_val("wrap.addr", addr, 32'hFFFF_FFFC);
    check_val("wrap.new_addr", new_addr, 32'h0);
    check_val("wrap.c_out", {31'd0, c_out}, 32'd1);
    redirect = 1'b0;
    step();
    check_val("wrapped.addr", addr, 32'h0);
    check_val("wrapped.new_addr", new_addr, 32'h4);
    check_val("wrapped.c_out", {31'd0, c_out}, 32'd0);

    // Adder on its own.
    add_a = 32'h7FFF_FFFF; add_b = 32'h1; add_cin = 1'b0;
    #1;
    check_val("add1.sum", add_sum, 32'h8000_0000);
    check_val("add1.c_out", {31'd0, add_cout}, 32'd0);
    add_a = 32'hFFFF_FFFF; add_b = 32'h0; add_cin = 1'b1;
    #1;
    check_val("add2.sum", add_sum, 32'h0);
    check_val("add2.c_out", {31'd0, add_cout}, 32'd1);
    add_a = 32'hA5A5_A5A5; add_b = 32'h5A5A_5A5B; add_cin = 1'b0;
    #1;
    check_val("add3.sum", add_sum, 32'h0);
    check_val("add3.c_out", {31'd0, add_cout}, 32'd1);
    add_a = 32'h1234_5678; add_b = 32'h1111_1111; add_cin = 1'b1;
    #1;
    check_val("add4.sum", add_sum, 32'h2345_678A);
    check_val("add4.c_out", {31'd0, add_cout}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
